vwb_history_buffer: RTL and testbench

- Parametrised successor to the single-stage virtual writeback register. It delays the writeback triple (destination register, write enable, data) by DEPTH cycles.
- Exposes NUM_RD combinational forwarding lookup ports that search every held stage for the youngest matching write.
- Sits after the WB mux. It feeds the RegFile write port and the hazard/forwarding unit, so retired results that have not yet landed in the RegFile still reach ID/EX.
- Adds flush support, which the single-stage version lacks.

---
 rtl/vwb_history_buffer.sv | 103 ++++++++++
 tb/tb_vwb_history_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vwb_history_buffer.sv
// Delays the writeback triple by DEPTH stages and forwards the youngest held write to NUM_RD lookup ports.
// Latency DEPTH unstalled edges; stall holds every stage and drops the input, flush clears every stage.
module vwb_history_buffer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [4:0]                 i_vwb_rdst,
  input  logic                       i_vwb_reg_write_rf,
  input  logic [WIDTH-1:0]           i_vwb_mux,
  input  logic [5*NUM_RD-1:0]        i_fwd_raddr,
  output logic [NUM_RD-1:0]          o_fwd_hit,
  output logic [WIDTH*NUM_RD-1:0]    o_fwd_data,
  output logic [4:0]                 o_vwb_rdst,
  output logic                       o_vwb_reg_write_rf,
  output logic [WIDTH-1:0]           o_vwb_mux,
  output logic [$clog2(DEPTH+1)-1:0] o_vwb_pending
);

  localparam int PW = $clog2(DEPTH+1);

  logic [4:0]       rdst_q [DEPTH];
  logic [4:0]       rdst_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] we_q, we_d;
  logic [PW-1:0]    pending_q, pending_d;

  always_comb begin
    we_d      = we_q;
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdst_d[i] = rdst_q[i];
      data_d[i] = data_q[i];
    end
    if (flush) begin
      we_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdst_d[i] = '0;
        data_d[i] = '0;
      end
    end else if (!stall) begin
      rdst_d[0] = i_vwb_rdst;
      we_d[0]   = i_vwb_reg_write_rf;
      data_d[0] = i_vwb_mux;
      for (int i = 1; i < DEPTH; i++) begin
        rdst_d[i] = rdst_q[i-1];
        we_d[i]   = we_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    // Pending is registered from the next-state enables so it tracks the stages exactly.
    for (int i = 0; i < DEPTH; i++) begin
      pending_d = pending_d + PW'(we_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= '0;
      pending_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdst_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      we_q      <= we_d;
      pending_q <= pending_d;
      for (int i = 0; i < DEPTH; i++) begin
        rdst_q[i] <= rdst_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  logic [4:0] raddr;

  // Scan oldest to youngest so the youngest matching stage overwrites any older hit.
  always_comb begin
    o_fwd_hit  = '0;
    o_fwd_data = '0;
    raddr      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      raddr = i_fwd_raddr[5*k +: 5];
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (we_q[i] && (rdst_q[i] == raddr) && (raddr != 5'd0)) begin
          o_fwd_hit[k]                 = 1'b1;
          o_fwd_data[WIDTH*k +: WIDTH] = data_q[i];
        end
      end
    end
  end

  assign o_vwb_rdst         = rdst_q[DEPTH-1];
  assign o_vwb_reg_write_rf = we_q[DEPTH-1];
  assign o_vwb_mux          = data_q[DEPTH-1];
  assign o_vwb_pending      = pending_q;

endmodule

// File: tb/tb_vwb_history_buffer.sv
// Directed bench for vwb_history_buffer with a queue-based reference model checked every negedge.
module tb_vwb_history_buffer;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 2;
  localparam int NUM_RD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, flush;
  logic [4:0]        i_vwb_rdst;
  logic              i_vwb_reg_write_rf;
  logic [WIDTH-1:0]  i_vwb_mux;
  logic [9:0]        i_fwd_raddr;
  logic [1:0]        o_fwd_hit;
  logic [63:0]       o_fwd_data;
  logic [4:0]        o_vwb_rdst;
  logic              o_vwb_reg_write_rf;
  logic [WIDTH-1:0]  o_vwb_mux;
  logic [1:0]        o_vwb_pending;

  int n_vec = 0;
  int n_err = 0;

  vwb_history_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .i_vwb_rdst(i_vwb_rdst), .i_vwb_reg_write_rf(i_vwb_reg_write_rf), .i_vwb_mux(i_vwb_mux),
    .i_fwd_raddr(i_fwd_raddr), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data),
    .o_vwb_rdst(o_vwb_rdst), .o_vwb_reg_write_rf(o_vwb_reg_write_rf), .o_vwb_mux(o_vwb_mux),
    .o_vwb_pending(o_vwb_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of held writes, youngest first.
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t zero_e = '{rd: 5'd0, we: 1'b0, d: 32'd0};

  function automatic void mclear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(zero_e);
  endfunction

  function automatic void mfwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    foreach (mq[i]) begin
      if (!h && a != 5'd0 && mq[i].we && mq[i].rd == a) begin
        h = 1'b1;
        d = mq[i].d;
      end
    end
  endfunction

  initial mclear();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mclear();
    end else if (flush) begin
      mclear();
    end else if (!stall) begin
      ent_t e;
      e.rd = i_vwb_rdst;
      e.we = i_vwb_reg_write_rf;
      e.d  = i_vwb_mux;
      mq.push_front(e);
      void'(mq.pop_back());
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic        h;
      logic [31:0] d;
      int          cnt;
      cnt = 0;
      foreach (mq[i]) cnt += int'(mq[i].we);
      chk("m_rdst", 64'(o_vwb_rdst), 64'(mq[DEPTH-1].rd));
      chk("m_we", 64'(o_vwb_reg_write_rf), 64'(mq[DEPTH-1].we));
      chk("m_mux", 64'(o_vwb_mux), 64'(mq[DEPTH-1].d));
      chk("m_pending", 64'(o_vwb_pending), 64'(cnt));
      for (int k = 0; k < NUM_RD; k++) begin
        mfwd(i_fwd_raddr[5*k +: 5], h, d);
        chk($sformatf("m_hit%0d", k), 64'(o_fwd_hit[k]), 64'(h));
        chk($sformatf("m_data%0d", k), 64'(o_fwd_data[32*k +: 32]), 64'(d));
      end
    end
  end

  // Drive a triple and control, then advance to just after the next rising edge.
  task automatic step(input logic [4:0] rd, input logic we, input logic [31:0] d,
                      input logic st, input logic fl);
    i_vwb_rdst         = rd;
    i_vwb_reg_write_rf = we;
    i_vwb_mux          = d;
    stall              = st;
    flush              = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [4:0] rd, input logic we,
                         input logic [31:0] d, input logic [1:0] p);
    chk({nm, "_rdst"}, 64'(o_vwb_rdst), 64'(rd));
    chk({nm, "_we"}, 64'(o_vwb_reg_write_rf), 64'(we));
    chk({nm, "_mux"}, 64'(o_vwb_mux), 64'(d));
    chk({nm, "_pend"}, 64'(o_vwb_pending), 64'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    i_vwb_rdst = '0; i_vwb_reg_write_rf = 1'b0; i_vwb_mux = '0;
    i_fwd_raddr = '0;

    // 1. reset and latency
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 5'd0, 1'b0, 32'd0, 2'd0);
    chk("rst_hit", 64'(o_fwd_hit), 64'd0);
    chk("rst_data", o_fwd_data, 64'd0);
    rst = 1'b1;
    i_fwd_raddr = {5'd0, 5'd5};
    step(5'd5, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    chk_out("lat1", 5'd0, 1'b0, 32'd0, 2'd1);
    chk("lat1_hit", 64'(o_fwd_hit), 64'd1);
    chk("lat1_data", 64'(o_fwd_data[31:0]), 64'hAAAA_0001);
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_out("lat2", 5'd5, 1'b1, 32'hAAAA_0001, 2'd1);
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_out("lat3", 5'd0, 1'b0, 32'd0, 2'd0);

    // 2. stall hold
    step(5'd3, 1'b1, 32'h33, 1'b0, 1'b0);
    step(5'd7, 1'b1, 32'h77, 1'b0, 1'b0);
    i_fwd_raddr = {5'd3, 5'd7};
    for (int i = 0; i < 4; i++) begin
      step(5'(10 + i), 1'b1, 32'(32'h100 + i), 1'b1, 1'b0);
      chk_out("stall", 5'd3, 1'b1, 32'h33, 2'd2);
      chk("stall_hit", 64'(o_fwd_hit), 64'd3);
      chk("stall_d0", 64'(o_fwd_data[31:0]), 64'h77);
    end
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_out("unstall", 5'd7, 1'b1, 32'h77, 2'd1);

    // 3. youngest wins
    step(5'd9, 1'b1, 32'h11, 1'b0, 1'b0);
    step(5'd9, 1'b1, 32'h22, 1'b0, 1'b0);
    i_fwd_raddr = {5'd8, 5'd9};
    #1;
    chk("yw_hit", 64'(o_fwd_hit), 64'd1);
    chk("yw_d0", 64'(o_fwd_data[31:0]), 64'h22);
    chk("yw_d1", 64'(o_fwd_data[63:32]), 64'h0);

    // 4. register zero
    step(5'd0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    i_fwd_raddr = {5'd9, 5'd0};
    #1;
    chk("r0_hit0", 64'(o_fwd_hit[0]), 64'd0);
    chk("r0_d0", 64'(o_fwd_data[31:0]), 64'd0);
    chk("r0_hit1", 64'(o_fwd_data[63:32]), 64'h22);
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_out("r0_drain", 5'd0, 1'b1, 32'hDEAD, 2'd1);

    // 5. flush overrides stall
    step(5'd4, 1'b1, 32'h44, 1'b0, 1'b0);
    step(5'd6, 1'b1, 32'h66, 1'b0, 1'b0);
    i_fwd_raddr = {5'd6, 5'd4};
    #1;
    chk("pre_fl_hit", 64'(o_fwd_hit), 64'd3);
    step(5'd12, 1'b1, 32'hCC, 1'b1, 1'b1);
    chk_out("flush", 5'd0, 1'b0, 32'd0, 2'd0);
    chk("flush_hit", 64'(o_fwd_hit), 64'd0);
    chk("flush_data", o_fwd_data, 64'd0);

    // 6. asynchronous reset mid-stream
    step(5'd1, 1'b1, 32'h1, 1'b0, 1'b0);
    step(5'd2, 1'b1, 32'h2, 1'b0, 1'b0);
    i_fwd_raddr = {5'd2, 5'd1};
    chk_out("pre_ar", 5'd1, 1'b1, 32'h1, 2'd2);
    #1 rst = 1'b0;
    #1;
    chk_out("ar", 5'd0, 1'b0, 32'd0, 2'd0);
    chk("ar_hit", 64'(o_fwd_hit), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    step(5'd8, 1'b1, 32'h88, 1'b0, 1'b0);
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_out("resume", 5'd8, 1'b1, 32'h88, 2'd1);
    step(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
